// File: rtl/srcopr_wakeup_buf.sv
// srcopr_wakeup_buf: operand wakeup/capture buffer between dispatch and one
// execution unit. Holds DEPTH instructions with two source operands each,
// snoops NCH result broadcasts to capture tagged operands (including at
// allocation), and issues the lowest-index fully ready entry via valid/ready.
//
// Ports:
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_kill                  flush all entries
//   i_alloc_*               allocation request (operand value or tag + dst tag)
//   i_bc_vld/tag/data       NCH result-broadcast channels, packed per channel
//   o_issue_vld, i_issue_rdy issue handshake
//   o_issue_src1/src2/dst_tag issued operands and destination tag (0 when idle)
//   o_full, o_count         occupancy
module srcopr_wakeup_buf #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned NCH    = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_kill,
    input  logic                      i_alloc_vld,
    input  logic                      i_alloc_src1_vld,
    input  logic                      i_alloc_src2_vld,
    input  logic [DATA_W-1:0]         i_alloc_src1,
    input  logic [DATA_W-1:0]         i_alloc_src2,
    input  logic [TAG_W-1:0]          i_alloc_dst_tag,
    input  logic [NCH-1:0]            i_bc_vld,
    input  logic [NCH*TAG_W-1:0]      i_bc_tag,
    input  logic [NCH*DATA_W-1:0]     i_bc_data,
    output logic                      o_issue_vld,
    input  logic                      i_issue_rdy,
    output logic [DATA_W-1:0]         o_issue_src1,
    output logic [DATA_W-1:0]         o_issue_src2,
    output logic [TAG_W-1:0]          o_issue_dst_tag,
    output logic                      o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]  ent_vld;
    logic [DEPTH-1:0]  s1_rdy;
    logic [DEPTH-1:0]  s2_rdy;
    logic [DATA_W-1:0] s1      [DEPTH];
    logic [DATA_W-1:0] s2      [DEPTH];
    logic [TAG_W-1:0]  dst_tag [DEPTH];

    logic [DEPTH-1:0]  cap1_hit;
    logic [DEPTH-1:0]  cap2_hit;
    logic [DATA_W-1:0] cap1_data [DEPTH];
    logic [DATA_W-1:0] cap2_data [DEPTH];
    logic              byp1_hit;
    logic              byp2_hit;
    logic [DATA_W-1:0] byp1_data;
    logic [DATA_W-1:0] byp2_data;

    logic              free_found;
    logic [IDX_W-1:0]  free_idx;
    logic              sel_found;
    logic [IDX_W-1:0]  sel_idx;
    logic [CNT_W-1:0]  cnt;
    logic              alloc_fire;
    logic              issue_fire;

    // Broadcast lookup: {hit, data} of the lowest-index channel matching tag.
    function automatic logic [DATA_W:0] bc_lookup(
        input logic [TAG_W-1:0]      tag,
        input logic [NCH-1:0]        bc_vld,
        input logic [NCH*TAG_W-1:0]  bc_tag,
        input logic [NCH*DATA_W-1:0] bc_data
    );
        logic [DATA_W:0] r;
        r = '0;
        for (int k = int'(NCH) - 1; k >= 0; k--) begin
            if (bc_vld[k] && (bc_tag[k*TAG_W +: TAG_W] == tag)) begin
                r = {1'b1, bc_data[k*DATA_W +: DATA_W]};
            end
        end
        return r;
    endfunction

    // Capture candidates for waiting operands and for the allocation bypass.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            {cap1_hit[i], cap1_data[i]} = bc_lookup(s1[i][TAG_W-1:0], i_bc_vld, i_bc_tag, i_bc_data);
            {cap2_hit[i], cap2_data[i]} = bc_lookup(s2[i][TAG_W-1:0], i_bc_vld, i_bc_tag, i_bc_data);
        end
        {byp1_hit, byp1_data} = bc_lookup(i_alloc_src1[TAG_W-1:0], i_bc_vld, i_bc_tag, i_bc_data);
        {byp2_hit, byp2_data} = bc_lookup(i_alloc_src2[TAG_W-1:0], i_bc_vld, i_bc_tag, i_bc_data);
    end

    // Lowest free slot, lowest ready slot, occupancy; descending scan so the
    // lowest index is the last one written.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        cnt        = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            cnt = cnt + CNT_W'(ent_vld[i]);
            if (!ent_vld[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (ent_vld[i] && s1_rdy[i] && s2_rdy[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign alloc_fire = i_alloc_vld && free_found && !i_kill;
    assign issue_fire = o_issue_vld && i_issue_rdy;
    assign o_count    = cnt;
    assign o_full     = (cnt == CNT_W'(DEPTH));

    // Issue outputs are zero whenever nothing is being offered.
    always_comb begin
        o_issue_vld     = sel_found && !i_kill;
        o_issue_src1    = '0;
        o_issue_src2    = '0;
        o_issue_dst_tag = '0;
        if (o_issue_vld) begin
            o_issue_src1    = s1[sel_idx];
            o_issue_src2    = s2[sel_idx];
            o_issue_dst_tag = dst_tag[sel_idx];
        end
    end

    // Entry state: kill overrides everything; the allocated slot is never a
    // valid entry, so it cannot collide with capture or issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ent_vld <= '0;
            s1_rdy  <= '0;
            s2_rdy  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                s1[i]      <= '0;
                s2[i]      <= '0;
                dst_tag[i] <= '0;
            end
        end else if (i_kill) begin
            ent_vld <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (ent_vld[i] && !s1_rdy[i] && cap1_hit[i]) begin
                    s1[i]     <= cap1_data[i];
                    s1_rdy[i] <= 1'b1;
                end
                if (ent_vld[i] && !s2_rdy[i] && cap2_hit[i]) begin
                    s2[i]     <= cap2_data[i];
                    s2_rdy[i] <= 1'b1;
                end
            end
            if (issue_fire) begin
                ent_vld[sel_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                ent_vld[free_idx] <= 1'b1;
                dst_tag[free_idx] <= i_alloc_dst_tag;
                s1_rdy[free_idx]  <= i_alloc_src1_vld || byp1_hit;
                s2_rdy[free_idx]  <= i_alloc_src2_vld || byp2_hit;
                s1[free_idx]      <= (!i_alloc_src1_vld && byp1_hit) ? byp1_data : i_alloc_src1;
                s2[free_idx]      <= (!i_alloc_src2_vld && byp2_hit) ? byp2_data : i_alloc_src2;
            end
        end
    end

endmodule

// File: tb/tb_srcopr_wakeup_buf.sv
// tb_srcopr_wakeup_buf: directed test of srcopr_wakeup_buf (default parameters).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_srcopr_wakeup_buf;

    logic         clk;
    logic         rst_n;
    logic         kill;
    logic         alloc_vld;
    logic         alloc_src1_vld;
    logic         alloc_src2_vld;
    logic [31:0]  alloc_src1;
    logic [31:0]  alloc_src2;
    logic [5:0]   alloc_dst_tag;
    logic [3:0]   bc_vld;
    logic [23:0]  bc_tag;
    logic [127:0] bc_data;
    logic         issue_vld;
    logic         issue_rdy;
    logic [31:0]  issue_src1;
    logic [31:0]  issue_src2;
    logic [5:0]   issue_dst_tag;
    logic         full;
    logic [3:0]   count;

    int total = 0;
    int bad   = 0;

    srcopr_wakeup_buf dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_kill           (kill),
        .i_alloc_vld      (alloc_vld),
        .i_alloc_src1_vld (alloc_src1_vld),
        .i_alloc_src2_vld (alloc_src2_vld),
        .i_alloc_src1     (alloc_src1),
        .i_alloc_src2     (alloc_src2),
        .i_alloc_dst_tag  (alloc_dst_tag),
        .i_bc_vld         (bc_vld),
        .i_bc_tag         (bc_tag),
        .i_bc_data        (bc_data),
        .o_issue_vld      (issue_vld),
        .i_issue_rdy      (issue_rdy),
        .o_issue_src1     (issue_src1),
        .o_issue_src2     (issue_src2),
        .o_issue_dst_tag  (issue_dst_tag),
        .o_full           (full),
        .o_count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        kill           = 1'b0;
        alloc_vld      = 1'b0;
        alloc_src1_vld = 1'b0;
        alloc_src2_vld = 1'b0;
        alloc_src1     = '0;
        alloc_src2     = '0;
        alloc_dst_tag  = '0;
        bc_vld         = '0;
        bc_tag         = '0;
        bc_data        = '0;
        issue_rdy      = 1'b0;
    endtask

    task automatic alloc(input logic v1, input logic [31:0] a1, input logic v2,
                         input logic [31:0] a2, input logic [5:0] d);
        alloc_vld      = 1'b1;
        alloc_src1_vld = v1;
        alloc_src1     = a1;
        alloc_src2_vld = v2;
        alloc_src2     = a2;
        alloc_dst_tag  = d;
    endtask

    task automatic bc(input int k, input logic [5:0] t, input logic [31:0] d);
        bc_vld[k]          = 1'b1;
        bc_tag[k*6 +: 6]   = t;
        bc_data[k*32 +: 32] = d;
    endtask

    // Advance to the next falling edge and return all inputs to idle.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_vld",   32'(issue_vld), 32'd0);
        chk("rst_count", 32'(count),     32'd0);
        chk("rst_full",  32'(full),      32'd0);
        chk("rst_src1",  issue_src1,     32'd0);
        rst_n = 1'b1;

        // 1: ready allocation issues next cycle
        step(); alloc(1'b1, 32'd5, 1'b1, 32'd7, 6'd3); #1;
        chk("t1_cnt_pre", 32'(count), 32'd0);
        step(); #1;
        chk("t1_count", 32'(count),         32'd1);
        chk("t1_vld",   32'(issue_vld),     32'd1);
        chk("t1_src1",  issue_src1,         32'd5);
        chk("t1_src2",  issue_src2,         32'd7);
        chk("t1_dst",   32'(issue_dst_tag), 32'd3);
        issue_rdy = 1'b1;
        step(); #1;
        chk("t1_pop_cnt", 32'(count), 32'd0);
        chk("t1_pop_src", issue_src1, 32'd0);

        // 2: wakeup via channel 2 two cycles after allocation
        step(); alloc(1'b0, 32'd9, 1'b1, 32'd1, 6'd5);
        step(); #1;
        chk("t2_wait1", 32'(issue_vld), 32'd0);
        step(); bc(2, 6'd9, 32'hDEAD); #1;
        chk("t2_wait2", 32'(issue_vld), 32'd0);
        step(); #1;
        chk("t2_vld",  32'(issue_vld),     32'd1);
        chk("t2_src1", issue_src1,         32'hDEAD);
        chk("t2_src2", issue_src2,         32'd1);
        chk("t2_dst",  32'(issue_dst_tag), 32'd5);
        issue_rdy = 1'b1;
        step(); #1;
        chk("t2_pop_cnt", 32'(count), 32'd0);

        // 3: allocation bypass on channel 0
        step(); alloc(1'b1, 32'h22, 1'b0, 32'd4, 6'd6); bc(0, 6'd4, 32'h11); #1;
        chk("t3_pre_vld", 32'(issue_vld), 32'd0);
        step(); #1;
        chk("t3_vld",  32'(issue_vld), 32'd1);
        chk("t3_src1", issue_src1,     32'h22);
        chk("t3_src2", issue_src2,     32'h11);
        issue_rdy = 1'b1;
        step(); #1;
        chk("t3_pop_cnt", 32'(count), 32'd0);

        // 4: fill with unready entries, drop when full, issue+alloc while full
        for (int i = 0; i < 8; i++) begin
            step(); alloc(1'b0, 32'(20 + i), 1'b1, 32'(i), 6'(i));
        end
        step(); #1;
        chk("t4_full",  32'(full),      32'd1);
        chk("t4_count", 32'(count),     32'd8);
        chk("t4_vld",   32'(issue_vld), 32'd0);
        alloc(1'b1, 32'd1, 1'b1, 32'd1, 6'd9);
        step(); #1;
        chk("t4_drop_cnt", 32'(count),     32'd8);
        chk("t4_drop_vld", 32'(issue_vld), 32'd0);
        bc(0, 6'd23, 32'h33);
        step(); #1;
        chk("t4_wake_vld",  32'(issue_vld),     32'd1);
        chk("t4_wake_src1", issue_src1,         32'h33);
        chk("t4_wake_dst",  32'(issue_dst_tag), 32'd3);
        issue_rdy = 1'b1;
        alloc(1'b1, 32'd1, 1'b1, 32'd1, 6'd9);
        step(); #1;
        chk("t4_ia_cnt",  32'(count),     32'd7);
        chk("t4_ia_full", 32'(full),      32'd0);
        chk("t4_ia_vld",  32'(issue_vld), 32'd0);
        kill = 1'b1;
        step(); #1;
        chk("t4_kill_cnt", 32'(count), 32'd0);

        // 5a: channel priority, ch1 beats ch3 on the same tag
        alloc(1'b0, 32'd2, 1'b1, 32'd0, 6'd7);
        step(); bc(1, 6'd2, 32'hA); bc(3, 6'd2, 32'hB);
        step(); #1;
        chk("t5_ch_vld",  32'(issue_vld), 32'd1);
        chk("t5_ch_src1", issue_src1,     32'hA);
        issue_rdy = 1'b1;
        step(); #1;
        chk("t5_ch_cnt", 32'(count), 32'd0);

        // 5b: issue priority, entries 2 and 5 ready; hold rdy low 3 cycles
        for (int i = 0; i < 6; i++) begin
            if (i == 2 || i == 5) alloc(1'b1, 32'(100 + i), 1'b1, 32'(200 + i), 6'(i));
            else                  alloc(1'b0, 32'd30, 1'b1, 32'd0, 6'(i));
            step();
        end
        #1;
        chk("t5_cnt6", 32'(count), 32'd6);
        for (int c = 0; c < 3; c++) begin
            chk("t5_hold_vld",  32'(issue_vld),     32'd1);
            chk("t5_hold_dst",  32'(issue_dst_tag), 32'd2);
            chk("t5_hold_src1", issue_src1,         32'd102);
            chk("t5_hold_src2", issue_src2,         32'd202);
            step(); #1;
        end
        issue_rdy = 1'b1;
        step(); #1;
        chk("t5_next_dst",  32'(issue_dst_tag), 32'd5);
        chk("t5_next_src1", issue_src1,         32'd105);
        chk("t5_next_cnt",  32'(count),         32'd5);

        // 6: kill with alloc and issue_rdy in the same cycle
        kill      = 1'b1;
        issue_rdy = 1'b1;
        alloc(1'b1, 32'd1, 1'b1, 32'd1, 6'd9);
        #1;
        chk("t6_kill_vld", 32'(issue_vld), 32'd0);
        step(); #1;
        chk("t6_cnt", 32'(count),     32'd0);
        chk("t6_vld", 32'(issue_vld), 32'd0);
        alloc(1'b1, 32'h55, 1'b1, 32'h66, 6'd1);
        step(); #1;
        chk("t6_re_cnt",  32'(count),     32'd1);
        chk("t6_re_vld",  32'(issue_vld), 32'd1);
        chk("t6_re_src1", issue_src1,     32'h55);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/srcopr_wakeup_buf.md
# srcopr_wakeup_buf

Parametrised operand wakeup/capture buffer: a generalised successor to single-operand forwarding. It holds up to DEPTH waiting instructions, each with two source operands. Each operand carries either a value or an RRF tag. The buffer snoops NCH result-broadcast channels every cycle and captures matching results, including same-cycle capture at allocation. It issues the lowest-index entry whose operands are both ready through a valid/ready handshake. It sits between dispatch and one execution unit's issue port.

## Interface
Parameters:
- DEPTH, 8: number of entries (power of two, ≥2)
- NCH, 4: number of result-broadcast channels (≥1)
- DATA_W, 32: operand width (`RV32_DATA_WIDTH`)
- TAG_W, 6: RRF tag width (`RRF_ENT_SEL`)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_kill  in  1  flush: invalidate all entries
- i_alloc_vld  in  1  allocate request
- i_alloc_src1_vld / i_alloc_src2_vld  in  1 each  operand holds a value (1) or a tag in [TAG_W-1:0] (0)
- i_alloc_src1 / i_alloc_src2  in  DATA_W each  value or tag
- i_alloc_dst_tag  in  TAG_W  destination RRF tag
- i_bc_vld  in  NCH  per-channel result valid
- i_bc_tag  in  NCH*TAG_W  channel k at [k*TAG_W +: TAG_W]
- i_bc_data  in  NCH*DATA_W  channel k at [k*DATA_W +: DATA_W]
- o_issue_vld  out  1  selected entry is ready
- i_issue_rdy  in  1  consumer accepts
- o_issue_src1 / o_issue_src2  out  DATA_W each  operand values
- o_issue_dst_tag  out  TAG_W  destination tag
- o_full  out  1  all entries occupied
- o_count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Per-entry state:
  - ent_vld
  - s1_rdy, s1
  - s2_rdy, s2
  - dst_tag
- **Allocation**
  - When i_alloc_vld && !o_full && !i_kill, the request writes the lowest-index entry with ent_vld=0 as seen at the start of the cycle.
  - If o_full is set, the request is dropped silently. The dispatch stage must gate on o_full.
- **Operand capture (waiting entries)**
  - Applies to each operand with rdy=0 in a valid entry.
  - Channel k matches when i_bc_vld[k] && i_bc_tag[k] == operand[TAG_W-1:0].
  - On a match: operand ← data of the lowest-index matching channel, and rdy ← 1.
  - An operand with rdy=1 never changes.
- **Allocation bypass**
  - An allocated operand with *_vld=0 is compared against the same-cycle broadcasts.
  - On a match, it is written with the broadcast data and rdy=1. Otherwise the tag is stored with rdy=0.
- **Issue selection**
  - sel = lowest index with ent_vld && s1_rdy && s2_rdy.
  - o_issue_vld = (sel exists) && !i_kill.
  - When o_issue_vld=1, the data outputs show entry sel. Otherwise they are 0.
  - When o_issue_vld && i_issue_rdy, ent_vld[sel] ← 0 at the edge.
- **Kill**
  - All ent_vld ← 0.
  - Allocation, capture and issue are ignored that cycle.
- **Derived outputs**
  - o_count = popcount(ent_vld).
  - o_full = (o_count == DEPTH).
  - Both are combinational from registered state.

## Timing
- Reset (asynchronous, i_rst_n=0):
  - All ent_vld, rdy and data registers clear to 0.
  - o_issue_vld=0, o_full=0, o_count=0, data outputs 0.
- Allocation latency:
  - An entry allocated at edge t is visible from cycle t+1.
  - If both operands are ready, including via bypass, o_issue_vld can rise in cycle t+1.
- Wakeup latency: a broadcast in cycle t sets rdy at edge t. The entry is issuable in t+1. There is no combinational broadcast-to-issue path.
- Simultaneous issue and allocation in one cycle, with the buffer full:
  - The freed slot is not reused that cycle, so the allocation is dropped.
  - o_count is unchanged if the buffer was not full; it drops by 1 if it was full.
- Simultaneous capture and issue of different entries: both take effect.
- o_issue_vld must be stable while i_issue_rdy=0; only kill or reset can drop it.
- Kill and reset may arrive mid-operation; there are no partial effects.
- Multiple channels matching the same tag: the lowest-index channel wins. This is defined behaviour.

## Test plan
1. **Reset, then ready allocation.** Reset, then allocate src1=5 (vld), src2=7 (vld), dst=3 → o_count=1 next cycle, o_issue_vld=1, src1=5, src2=7, dst=3. With i_issue_rdy=1 → o_count=0 the following cycle.
2. **Wakeup via broadcast.** Allocate src1 tag 9 (not vld), src2=1. Two cycles later broadcast ch2 tag 9 data 0xDEAD → o_issue_vld=0 until the cycle after the broadcast, then src1=0xDEAD.
3. **Allocation bypass.** Allocate src2 tag 4 in the same cycle as ch0 tag 4 data 0x11 → next cycle o_issue_vld=1, src2=0x11.
4. **Fill and drop.** Fill all DEPTH=8 entries with unready operands → o_full=1. A 9th alloc is dropped (o_count stays 8). Issue + alloc in one cycle while full → o_count=7.
5. **Priority.** Channel priority: ch1 and ch3 both broadcast tag 2, with data 0xA and 0xB → captured value 0xA. Issue priority: entries 2 and 5 ready → entry 2 issues first. Hold i_issue_rdy=0 for 3 cycles → outputs stable.
6. **Kill mid-operation.** With 5 entries valid, assert i_kill together with an alloc and i_issue_rdy=1 → o_issue_vld=0 that cycle, o_count=0 next cycle, no entry allocated.
